// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - synchronous parametrised up/down counter with wrap/saturate and status flags
//
// Purpose:
//   General event/position counter. Every bit is clocked on the same clk
//   edge. The count range is 0..MODULUS-1, and all arithmetic is modulo
//   MODULUS. When the count reaches a range limit it either wraps or
//   saturates. Beyond counting, the block provides synchronous clear,
//   parallel load with clamping, a combinational terminal count, a
//   one-cycle wrap pulse and sticky overflow/underflow flags.
//
// Parameters:
//   WIDTH    counter width in bits (>= 1)
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE 0 = wrap at the range limits, 1 = hold at the range limits
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active high
//   en        in   1      count enable, one step per clk while high
//   up        in   1      direction: 1 = up, 0 = down
//   clr       in   1      synchronous clear to 0 (highest priority)
//   load      in   1      synchronous parallel load (below clr)
//   load_val  in   WIDTH  value to load, clamped to MODULUS-1
//   q         out  WIDTH  registered count
//   qbar      out  WIDTH  registered bitwise complement of q
//   tc        out  1      terminal count (combinational)
//   wrap      out  1      one-cycle pulse after a wrap (registered)
//   ovf       out  1      sticky up-limit flag
//   unf       out  1      sticky down-limit flag

module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  // Limits are held one bit wider than the counter. This lets
  // MODULUS == 2**WIDTH be represented and compared without truncation.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             ovf_next;
  logic             unf_next;

  assign q_ext    = {1'b0, q};
  assign load_ext = {1'b0, load_val};
  assign at_max   = (q_ext == MAX_EXT);
  assign at_zero  = (q == '0);

  // A load value outside the count range is clamped to the top of the
  // range, so q can never leave 0..MODULUS-1.
  assign load_clamped = (load_ext > MAX_EXT) ? MAX_VAL : load_val;

  // Terminal count tells the user that the next enabled step hits a limit.
  // It is suppressed while clr or load has priority over the count.
  assign tc = en & ~clr & ~load & ((up & at_max) | (~up & at_zero));

  // Next-state selection with priority clr > load > en. The wrap pulse
  // defaults low, so it only survives for the one cycle after a wrap.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    ovf_next  = ovf;
    unf_next  = unf;
    if (clr) begin
      q_next   = '0;
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end else if (load) begin
      q_next = load_clamped;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_next = 1'b1;
          if (!SATURATE) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          unf_next = 1'b1;
          if (!SATURATE) begin
            q_next    = MAX_VAL;
            wrap_next = 1'b1;
          end
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

  // qbar is registered from the same next-state value as q, so the two
  // outputs are always complementary, including straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      qbar <= '1;
      wrap <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      q    <= q_next;
      qbar <= ~q_next;
      wrap <= wrap_next;
      ovf  <= ovf_next;
      unf  <= unf_next;
    end
  end

endmodule
